btn_event_fifo: RTL

//  Consumes the one-cycle debounced pulses from an array of one_pulse de-bouncers.

---
 rtl/btn_event_if.sv | 21 ++
 rtl/btn_event_fifo.sv | 128 ++++++++++++
 2 files changed

// File: rtl/btn_event_if.sv
// Event handshake bundle between the button event FIFO and its consumer.
// The master side drives the head event; the slave side returns ready.
interface btn_event_if #(
  parameter int ID_W = 2
) ();
  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic            evt_ready;

  modport master (
    output evt_valid,
    output evt_id,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    output evt_ready
  );
endinterface

// File: rtl/btn_event_fifo.sv
// Button event FIFO: converts one-cycle debounced press pulses into ordered
// button-ID events. A pending mask absorbs presses while the FIFO is busy;
// one pending button (lowest index first) is pushed per cycle into a
// show-ahead FIFO. Presses that hit an already-pending button are merged and
// flagged through a sticky overflow bit.
module btn_event_fifo #(
  parameter int N_BTN = 4,
  parameter int ID_W  = 2,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] pulse_in,
  btn_event_if.master      evt,
  output logic [AW:0]      evt_count,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  // Stage 1 state: presses waiting for a FIFO slot
  logic [N_BTN-1:0] pending_q, pending_d;

  // Stage 2 state: FIFO storage, pointers and occupancy
  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  // Registered show-ahead head and sticky overflow
  logic             valid_q, valid_d;
  logic [ID_W-1:0]  head_q, head_d;
  logic             ovf_q, ovf_d;

  logic             full;
  logic             push;
  logic             pop;
  logic [N_BTN-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic [N_BTN-1:0] drop_vec;
  logic             drop;

  assign full = (count_q == DEPTH_C);
  assign pop  = valid_q & evt.evt_ready;

  // Priority pick of the lowest-index pending button; no pick while full so
  // the entry simply stays pending until a slot frees up.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    push      = 1'b0;
    if (!full) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (pending_q[i] && !push) begin
          grant[i]  = 1'b1;
          grant_idx = ID_W'(i);
          push      = 1'b1;
        end
      end
    end
  end

  // A press on a button that is pending and not leaving this cycle is lost.
  // A press on the button being granted re-arms it instead.
  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_drop
      assign drop_vec[gi] = pulse_in[gi] & pending_q[gi] & ~grant[gi];
    end
  endgenerate

  assign drop = |drop_vec;

  // Next-state for pointers, occupancy, pending mask, overflow and the head.
  always_comb begin
    pending_d = (pending_q & ~grant) | pulse_in;
    wr_ptr_d  = wr_ptr_q + AW'(push);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    count_d   = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    ovf_d     = (ovf_q & ~ovf_clr) | drop;
    valid_d   = (count_d != '0);
    head_d    = '0;
    if (count_d != '0) begin
      // Bypass the entry being written when it becomes the new head
      // (empty FIFO, or the single remaining entry is popped).
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        head_d = grant_idx;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  // Control and status registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      head_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      head_q    <= head_d;
      ovf_q     <= ovf_d;
    end
  end

  // FIFO storage write; contents need no reset since occupancy gates use.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= grant_idx;
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_id    = head_q;
  assign evt_count     = count_q;
  assign overflow      = ovf_q;

endmodule
